alu_exec_pipe: RTL

Two-stage pipelined ALU execution unit that consumes the 4-bit `func` code produced by the datapath's ALU-control decoder, together with two operands. It returns the result, zero/overflow flags and an illegal-op indication over a valid/ready handshake. It sits between decode and writeback/branch resolution, and holds results under backpressure so that later multi-cycle datapath variants can stall it.

---
 rtl/alu_exec_pipe_if.sv | 27 ++
 rtl/alu_exec_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe_if.sv
// Request/response bundle for the two-stage ALU execution unit.
// master drives requests and accepts results; slave is the execution unit.
interface alu_exec_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, func, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, func, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage pipelined ALU execution unit: S1 captures the request, S2 holds
// the computed result and flags. Valid/ready handshake on both sides, with
// up to two ops buffered under backpressure. Counts delivered illegal ops.
module alu_exec_pipe #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_pipe_if.slave       bus,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_NOR = 4'd4;
    localparam logic [3:0] FN_XOR = 4'd5;
    localparam logic [3:0] FN_SLT = 4'd6;
    localparam logic [3:0] FN_LUI = 4'd7;
    localparam logic [3:0] FN_NEQ = 4'd8;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    logic                 s1_v_q, s1_v_d;
    logic [3:0]           s1_func_q, s1_func_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    logic                 s2_v_q, s2_v_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 illegal_q, illegal_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 adv2;
    logic                 in_hs;
    logic                 s1_xfer;
    logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;
    logic                 alu_ill;

    // S2 may take new data when empty or when its result is being consumed;
    // in_ready depends only on state and out_ready, never on in_valid.
    assign adv2         = !s2_v_q || bus.out_ready;
    assign bus.in_ready = !s1_v_q || adv2;
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign s1_xfer      = s1_v_q && adv2;

    assign a_s    = s1_a_q;
    assign b_s    = s1_b_q;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    // ---- S1 -> S2 boundary: combinational ALU on the S1 contents ----
    // Decode func and produce result, signed-overflow and illegal indication.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (s1_func_q)
            FN_ADD: begin
                alu_res = sum_s;
                alu_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            FN_SUB: begin
                alu_res = diff_s;
                alu_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            FN_AND:  alu_res = s1_a_q & s1_b_q;
            FN_OR:   alu_res = s1_a_q | s1_b_q;
            FN_NOR:  alu_res = ~(s1_a_q | s1_b_q);
            FN_XOR:  alu_res = s1_a_q ^ s1_b_q;
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            FN_LUI:  alu_res[31:16] = s1_b_q[15:0];
            FN_NEQ:  alu_res = {{(WIDTH-1){1'b0}}, (s1_a_q != s1_b_q)};
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state for both pipeline stages and the illegal-op counter.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_func_d = s1_func_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s2_v_d    = s2_v_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        err_cnt_d = err_cnt_q;

        // ---- input -> S1 boundary ----
        if (in_hs) begin
            s1_v_d    = 1'b1;
            s1_func_d = bus.func;
            s1_a_d    = bus.op_a;
            s1_b_d    = bus.op_b;
        end else if (s1_xfer) begin
            s1_v_d = 1'b0;
        end

        // ---- S1 -> S2 boundary ----
        if (adv2) begin
            s2_v_d = s1_v_q;
        end
        if (s1_xfer) begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            ovf_d     = alu_ovf;
            illegal_d = alu_ill;
        end

        // Clear wins over an increment in the same cycle.
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (s1_xfer && alu_ill) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    // State registers; reset drops in-flight ops and clears visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_func_q <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s2_v_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_func_q <= s1_func_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s2_v_q    <= s2_v_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.out_valid = s2_v_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
    assign err_count     = err_cnt_q;
endmodule
